// File: rtl/spi_ram_responder.sv
// SPI mode-0 byte-addressed RAM responder: 0x02 write / 0x03 read, streaming with pointer wrap.
// All SPI pins are oversampled in the clk domain through 2-flop synchronizers.
module spi_ram_responder #(
    parameter int unsigned ADDR_BITS     = 16,
    parameter int unsigned MEM_ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_select,
    input  logic                     spi_clk_in,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     busy,
    output logic                     cmd_error,
    input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
    output logic [7:0]               dbg_data
);

    localparam int unsigned DEPTH   = 2 ** MEM_ADDR_BITS;
    localparam int unsigned CNT_MAX = (ADDR_BITS > 8) ? ADDR_BITS : 8;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    // Only the low address bits survive the shift, so the register is no wider than needed.
    localparam int unsigned SH_W    = (MEM_ADDR_BITS > 8) ? MEM_ADDR_BITS : 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_RD     = 3'd3,
        S_WR     = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic sel_s1_q, sel_s2_q, sel_d_q;
    logic sck_s1_q, sck_s2_q, sck_d_q;
    logic mosi_s1_q, mosi_s2_q;
    logic [1:0] settle_q;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SH_W-2:0]          shift_q, shift_d;
    logic [MEM_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [7:0]               tx_q, tx_d;
    logic                     wr_q, wr_d;
    logic                     miso_q, miso_d;
    logic                     cmd_err_q, cmd_err_d;
    logic                     busy_q;

    logic [7:0] mem_q [DEPTH];

    logic                     sck_rise_c, sck_fall_c, sel_fall_c;
    logic                     cnt_zero_c, cmd_ok_c, mem_we_c;
    logic [SH_W-1:0]          shift_in_c;
    logic [MEM_ADDR_BITS-1:0] addr_c;

    // A select fall only counts once the synchronizer chain holds real pin values after reset.
    assign sck_rise_c = sck_s2_q & ~sck_d_q;
    assign sck_fall_c = ~sck_s2_q & sck_d_q;
    assign sel_fall_c = ~sel_s2_q & sel_d_q & (settle_q == 2'd3);
    assign cnt_zero_c = (cnt_q == '0);
    assign shift_in_c = {shift_q, mosi_s2_q};
    assign cmd_ok_c   = (shift_in_c[7:0] == 8'h03) || (shift_in_c[7:0] == 8'h02);
    assign addr_c     = shift_in_c[MEM_ADDR_BITS-1:0];

    assign spi_miso  = miso_q;
    assign busy      = busy_q;
    assign cmd_error = cmd_err_q;
    assign dbg_data  = mem_q[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_s1_q  <= 1'b1;
            sel_s2_q  <= 1'b1;
            sel_d_q   <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_d_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            settle_q  <= 2'd0;
        end else begin
            sel_s1_q  <= spi_select;
            sel_s2_q  <= sel_s1_q;
            sel_d_q   <= sel_s2_q;
            sck_s1_q  <= spi_clk_in;
            sck_s2_q  <= sck_s1_q;
            sck_d_q   <= sck_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Select deasserted aborts any transaction; otherwise advance on completed bit groups.
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && sel_s2_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (sel_fall_c) state_d = S_CMD;
                S_CMD:  if (sck_rise_c && cnt_zero_c) state_d = cmd_ok_c ? S_ADDR : S_IGNORE;
                S_ADDR: if (sck_rise_c && cnt_zero_c) state_d = wr_q ? S_WR : S_RD;
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        tx_d      = tx_q;
        wr_d      = wr_q;
        cmd_err_d = 1'b0;
        mem_we_c  = 1'b0;
        miso_d    = (state_q == S_RD && state_d == S_RD) ? miso_q : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_CMD) begin
                    cnt_d   = CNT_W'(7);
                    shift_d = '0;
                end
            end
            S_CMD: begin
                if (sck_rise_c) begin
                    shift_d = shift_in_c[SH_W-2:0];
                    if (cnt_zero_c) begin
                        cnt_d     = CNT_W'(ADDR_BITS - 1);
                        wr_d      = (shift_in_c[7:0] == 8'h02);
                        cmd_err_d = ~cmd_ok_c;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_ADDR: begin
                if (sck_rise_c) begin
                    shift_d = shift_in_c[SH_W-2:0];
                    if (cnt_zero_c) begin
                        cnt_d = CNT_W'(7);
                        if (wr_q) begin
                            ptr_d = addr_c;
                        end else begin
                            tx_d  = mem_q[addr_c];
                            ptr_d = addr_c + MEM_ADDR_BITS'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_RD: begin
                // Falls shift the byte out; after bit 0 prefetch the next byte.
                if (sck_fall_c && state_d == S_RD) begin
                    miso_d = tx_q[cnt_q[2:0]];
                    if (cnt_zero_c) begin
                        tx_d  = mem_q[ptr_q];
                        ptr_d = ptr_q + MEM_ADDR_BITS'(1);
                        cnt_d = CNT_W'(7);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_WR: begin
                // A completed byte commits even if select rose in the same cycle.
                if (sck_rise_c) begin
                    shift_d = shift_in_c[SH_W-2:0];
                    if (cnt_zero_c) begin
                        mem_we_c = 1'b1;
                        ptr_d    = ptr_q + MEM_ADDR_BITS'(1);
                        cnt_d    = CNT_W'(7);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            tx_q      <= '0;
            wr_q      <= 1'b0;
            miso_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            tx_q      <= tx_d;
            wr_q      <= wr_d;
            miso_q    <= miso_d;
            cmd_err_q <= cmd_err_d;
            busy_q    <= ~sel_s2_q;
        end
    end

    // Backing store is not reset; contents persist across rst.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[ptr_q] <= shift_in_c[7:0];
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI write/read streaming, wrap, bad command, partial byte, reset abort.
module tb_spi_ram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_select;
    logic       spi_clk_in;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy;
    logic       cmd_error;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks      = 0;
    int failures    = 0;
    int err_pulses  = 0;
    int miso_hits   = 0;

    spi_ram_responder #(.ADDR_BITS(16), .MEM_ADDR_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_select (spi_select),
        .spi_clk_in (spi_clk_in),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .busy       (busy),
        .cmd_error  (cmd_error),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_error) err_pulses++;
        if (spi_miso)  miso_hits++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #10;
        chk(tag, dbg_data, exp);
    endtask

    // One SCK period of 10 clk; MISO is captured at the rising edge like a mode-0 initiator.
    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        #50;
        spi_clk_in = 1'b1;
        r = spi_miso;
        #50;
        spi_clk_in = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_low();
        spi_select = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100;
        spi_select = 1'b1;
        #100;
    endtask

    initial begin
        logic [7:0] rx;
        logic       rb;
        int         e0;
        int         m0;

        rst        = 1'b1;
        spi_select = 1'b1;
        spi_clk_in = 1'b0;
        spi_mosi   = 1'b0;
        dbg_addr   = 8'h00;
        repeat (3) @(posedge clk);
        #5;
        rst = 1'b0;
        #10;
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_miso", {7'd0, spi_miso}, 8'h00);
        chk("reset_cmd_error", {7'd0, cmd_error}, 8'h00);

        // Write 0xA5 0x5A at 0x0010
        cs_low();
        chk("busy_active", {7'd0, busy}, 8'h01);
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'hA5, rx);
        spi_byte(8'h5A, rx);
        cs_high();
        chk_mem("wr_mem10", 8'h10, 8'hA5);
        chk_mem("wr_mem11", 8'h11, 8'h5A);

        // Streaming read back of 0x0010
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        chk("rd_byte0", rx, 8'hA5);
        spi_byte(8'h00, rx);
        chk("rd_byte1", rx, 8'h5A);
        cs_high();

        // Pointer wrap 0xFF -> 0x00 for write and read
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_high();
        chk_mem("wrap_memFF", 8'hFF, 8'h11);
        chk_mem("wrap_mem00", 8'h00, 8'h22);
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        chk("wrap_rd0", rx, 8'h11);
        spi_byte(8'h00, rx);
        chk("wrap_rd1", rx, 8'h22);
        cs_high();

        // Unknown command 0x0B followed by write-like traffic
        e0 = err_pulses;
        m0 = miso_hits;
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'hFF, rx);
        cs_high();
        chk("bad_cmd_pulses", 8'(err_pulses - e0), 8'h01);
        chk("bad_cmd_miso", 8'(miso_hits - m0), 8'h00);
        chk_mem("bad_cmd_mem10", 8'h10, 8'hA5);

        // Partial byte at 0x0020 is discarded
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'h77, rx);
        cs_high();
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
        #100;
        spi_select = 1'b1;
        #10;
        chk("busy_after_1clk", {7'd0, busy}, 8'h01);
        #20;
        chk("busy_after_3clk", {7'd0, busy}, 8'h00);
        #70;
        chk_mem("partial_mem20", 8'h20, 8'h77);

        // Reset mid-address; traffic under the still-low select must be ignored
        cs_low();
        spi_byte(8'h02, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, rb);
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #100;
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'h99, rx);
        cs_high();
        chk_mem("rst_stale_mem20", 8'h20, 8'h77);
        cs_low();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'h3C, rx);
        cs_high();
        chk_mem("rst_fresh_mem05", 8'h05, 8'h3C);
        chk_mem("rst_keep_mem11", 8'h11, 8'h5A);
        chk_mem("rst_keep_mem00", 8'h00, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, the width of the SPI address phase in bits.
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 8, giving a backing store of 2^MEM_ADDR_BITS bytes.
REQ-003 clk  input  1  system clock; single clock domain; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_select  input  1  chip select, active low; asynchronous to clk.
REQ-006 spi_clk_in  input  1  SPI clock, mode 0 (idle low); asynchronous; frequency at most clk/4.
REQ-007 spi_mosi  input  1  serial data from the initiator, MSB first.
REQ-008 spi_miso  output  1  serial data to the initiator, MSB first.
REQ-009 busy  output  1  high while synchronized select is low.
REQ-010 cmd_error  output  1  one-cycle pulse when a complete command byte is neither 0x02 nor 0x03.
REQ-011 dbg_addr  input  MEM_ADDR_BITS  backdoor read address.
REQ-012 dbg_data  output  8  combinational backdoor read of the store at dbg_addr.

Function
REQ-013 SHALL pass spi_select, spi_clk_in and spi_mosi through 2-flop synchronizers; all decoding SHALL use the synchronized values.
REQ-014 SHALL detect SCK rise and fall as single-cycle events from the synchronized SCK and its one-cycle-delayed copy.
REQ-015 SHALL sample MOSI only on SCK rise events, and SHALL change spi_miso only on SCK fall events.
REQ-016 SHALL implement states IDLE, CMD, ADDR, RD, WR and IGNORE.
REQ-017 IDLE -> CMD when synchronized select falls; bit counter = 7, shift register = 0.
REQ-018 CMD: shift in 8 bits; on the 8th rise, 0x03 -> ADDR (read), 0x02 -> ADDR (write), other -> IGNORE and pulse cmd_error.
REQ-019 ADDR: shift in ADDR_BITS bits MSB first; on the last rise, go to RD or WR; the address pointer = low MEM_ADDR_BITS bits; upper bits are ignored.
REQ-020 RD: on the ADDR->RD transition, load the output byte from mem[ptr] and increment ptr.
REQ-021 RD: the first SCK fall in RD drives bit 7; each following fall drives the next bit.
REQ-022 RD: after the fall driving bit 0, reload the output byte from mem[ptr] and increment ptr, so reads stream without limit.
REQ-023 WR: collect 8 rise-sampled bits; on the 8th, write mem[ptr] <= byte and increment ptr; repeat until select rises.
REQ-024 IGNORE: drop all SCK activity until select rises.
REQ-025 ptr SHALL increment modulo 2^MEM_ADDR_BITS (0xFF -> 0x00 at default).
REQ-026 A synchronized select rise in any state SHALL force IDLE on the next cycle and discard any partial write byte, with no memory write.
REQ-027 A select rise on the same cycle as the 8th WR rise SHALL still commit that completed byte.
REQ-028 spi_miso SHALL be 0 in every state other than RD.
REQ-029 busy SHALL be the inverse of synchronized select.
REQ-030 The store SHALL be a write-only-via-SPI byte array; dbg_data SHALL reflect a write from the cycle after it occurs.

Reset
REQ-031 rst high on a posedge clk SHALL set state IDLE, spi_miso 0, cmd_error 0, counters and pointer 0, and synchronizers to select=1, SCK=0, MOSI=0.
REQ-032 rst SHALL NOT clear the memory contents; contents are undefined until written.
REQ-033 rst mid-transaction SHALL abort without a memory write; the responder SHALL wait for select to fall anew before accepting a command.

Verification
REQ-034 Write 0x02, addr 0x0010, data 0xA5 0x5A, then raise select -> dbg_data shows 0xA5 at 0x10 and 0x5A at 0x11.
REQ-035 After REQ-034, read 0x03, addr 0x0010, 16 SCKs -> bits sampled on SCK rise give 0xA5 then 0x5A.
REQ-036 Write at 0x00FF with data 0x11 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22; reading 2 bytes at 0x00FF returns 0x11 0x22.
REQ-037 Command 0x0B -> exactly one cmd_error pulse, spi_miso stays 0, memory unchanged.
REQ-038 Write 0x02 to addr 0x0020 with 4 data bits, then raise select -> mem[0x20] unchanged, busy low 2-3 clk after select rises.
REQ-039 Assert rst mid-address, then do a fresh write of 0x3C to 0x0005 -> only mem[0x05]=0x3C changes.
